wishbone_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Wishbone classic slave bus between NUM_MASTERS masters
//  (e.g. cpu instruction fetch, cpu load/store, debug/DMA) ahead of memory/flash decode.

---
 rtl/wishbone_pkg.sv | 10 +
 rtl/rr_priority_picker.sv | 26 ++
 rtl/wishbone_arbiter.sv | 115 +++++++++++
 tb/tb_wishbone_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone round-robin arbiter: FSM states and the byte-select width rule.
package wishbone_pkg;

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} arb_state_e;

  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after (last+1) mod N, one-hot.
module rr_priority_picker #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone classic arbiter granting whole cyc tenures to NUM_MASTERS masters.
// Optional slave watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = sel_width(DATA_WIDTH),
  localparam int PW            = $clog2(NUM_MASTERS)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic                              cyc_o,
  output logic                              stb_o,
  output logic                              we_o,
  output logic [ADDR_WIDTH-1:0]             adr_o,
  output logic [SEL_WIDTH-1:0]              sel_o,
  output logic [DATA_WIDTH-1:0]             dat_o,
  input  logic [DATA_WIDTH-1:0]             dat_i,
  input  logic                              ack_i,
  input  logic                              err_i,
  input  logic                              rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  arb_state_e             state;
  logic [PW-1:0]          last, owner;
  logic [NUM_MASTERS-1:0] grant, next_grant, live;
  logic                   owner_cyc, timeout_hit;

  rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (next_grant)
  );

  // Everything on the bus is gated by the owner's own cyc, so a drop frees the bus at once.
  assign live      = grant & m_cyc_i;
  assign owner_cyc = |live;
  assign grant_o   = grant;
  assign m_dat_o   = dat_i;
  assign m_ack_o   = live & {NUM_MASTERS{ack_i}};
  assign m_rty_o   = live & {NUM_MASTERS{rty_i}};
  assign m_err_o   = live & {NUM_MASTERS{err_i | timeout_hit}};
  assign cyc_o     = owner_cyc;
  assign stb_o     = (|(live & m_stb_i)) & ~timeout_hit;
  assign we_o      = |(live & m_we_i);

  always_comb begin
    owner = '0;
    adr_o = '0;
    sel_o = '0;
    dat_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) owner = PW'(k);
      if (live[k]) begin
        adr_o |= m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_o |= m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        dat_o |= m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= PW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: if (|m_cyc_i) begin
          grant <= next_grant;
          state <= GRANTED;
        end
        GRANTED: if (!owner_cyc) begin
          last  <= owner;
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Hit cycle errors the owner and suppresses stb; the owner still holds the grant.
  assign timeout_hit = owner_cyc && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || state != GRANTED || !owner_cyc || timeout_hit || ack_i || err_i || rty_i)
      tmo_cnt <= '0;
    else if (stb_o)
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter with two masters and a one-cycle-ack word memory slave.
module tb_wishbone_arbiter;

  localparam int NM = 2, AW = 32, DW = 32, SW = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*SW-1:0]  m_sel_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
  logic              cyc_o, stb_o, we_o;
  logic [AW-1:0]     adr_o;
  logic [SW-1:0]     sel_o;
  logic [DW-1:0]     dat_o;
  logic [DW-1:0]     dat_i = '0;
  logic              ack_i = 1'b0, err_i = 1'b0;
  logic              rty_i = 1'b0;

  int n_chk = 0, n_pass = 0;
  int slave_mode = 0;  // 0 ack, 1 err, 2 stall
  logic [DW-1:0] mem [0:15];

  always #5 clk = ~clk;

  wishbone_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
    .grant_o(grant_o)
  );

  // Word memory slave: terminates one cycle after seeing stb, memory reloads on reset.
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0] <= 32'h0000_0001;
    end
    if (cyc_o && stb_o && !ack_i && !err_i && slave_mode != 2) begin
      if (slave_mode == 1) err_i <= 1'b1;
      else begin
        ack_i <= 1'b1;
        if (we_o) mem[adr_o[5:2]] <= dat_o;
        else dat_i <= mem[adr_o[5:2]];
      end
    end else begin
      ack_i <= 1'b0;
      err_i <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[m] = cyc;
    m_stb_i[m] = stb;
    m_we_i[m]  = we;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
    m_sel_i[m*SW +: SW] = '1;
  endtask

  // Waits (bounded) for termination of master m, captures outputs, drops its stb.
  task automatic wait_term(input int m, output logic [NM-1:0] ack, output logic [NM-1:0] err,
                           output logic [DW-1:0] rd);
    logic done;
    done = 1'b0;
    ack = '0; err = '0; rd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_ack_o[m] || m_err_o[m]) begin
        ack = m_ack_o; err = m_err_o; rd = m_dat_o;
        m_stb_i[m] = 1'b0;
        done = 1'b1;
      end else @(negedge clk);
    end
    if (!done) chk("term_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    logic [NM-1:0] ack, err;
    logic [DW-1:0] rd;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_ack", m_ack_o, 0);
    rst_i = 1'b0;

    // single request from master 0
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    #1;
    chk("t1_latency", grant_o, 2'b00);
    chk("t1_cyc_pre", cyc_o, 0);
    @(negedge clk);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_adr", adr_o, 32'h2000_0000);
    wait_term(0, ack, err, rd);
    chk("t1_ack", ack, 2'b01);
    chk("t1_rdata", rd, 32'h0000_0001);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t1_idle", grant_o, 2'b00);

    // contention straight after reset
    do_reset();
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    drv(1, 1, 1, 1, 32'h2000_000C, 32'hCAFE_0001);
    @(negedge clk);
    chk("t2_first", grant_o, 2'b01);
    wait_term(0, ack, err, rd);
    chk("t2_m0_ack", ack, 2'b01);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t2_gap1", grant_o, 2'b00);
    @(negedge clk);
    chk("t2_second", grant_o, 2'b10);
    chk("t2_we", we_o, 1);
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    wait_term(1, ack, err, rd);
    chk("t2_m1_ack", ack, 2'b10);
    drv(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t2_gap2", grant_o, 2'b00);
    @(negedge clk);
    chk("t2_third", grant_o, 2'b01);
    chk("t2_mem3", mem[3], 32'hCAFE_0001);
    wait_term(0, ack, err, rd);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);

    // locked tenure: master 1 holds cyc across a stb gap while master 0 waits
    drv(1, 1, 1, 1, 32'h2000_0004, 32'hA5A5_0004);
    @(negedge clk);
    chk("t3_grant", grant_o, 2'b10);
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    wait_term(1, ack, err, rd);
    chk("t3_beat1", ack, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold", grant_o, 2'b10);
      chk("t3_m0_noack", m_ack_o[0], 0);
    end
    drv(1, 1, 1, 1, 32'h2000_0008, 32'h5A5A_0008);
    wait_term(1, ack, err, rd);
    chk("t3_beat2", ack, 2'b10);
    drv(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    chk("t3_gap", grant_o, 2'b00);
    @(negedge clk);
    chk("t3_m0_turn", grant_o, 2'b01);
    chk("t3_mem1", mem[1], 32'hA5A5_0004);
    chk("t3_mem2", mem[2], 32'h5A5A_0008);
    wait_term(0, ack, err, rd);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);

    // error routing to master 1
    slave_mode = 1;
    drv(1, 1, 1, 0, 32'h2000_0000, '0);
    @(negedge clk);
    wait_term(1, ack, err, rd);
    chk("t4_err", err, 2'b10);
    chk("t4_ack", ack, 2'b00);
    drv(1, 0, 0, 0, '0, '0);
    slave_mode = 0;
    @(negedge clk);

    // reset during a stalled master 0 access
    slave_mode = 2;
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    @(negedge clk);
    chk("t5_grant", grant_o, 2'b01);
    @(negedge clk);
    chk("t5_stall_cyc", cyc_o, 1);
    rst_i = 1'b1;
    slave_mode = 0;
    @(negedge clk);
    chk("t5_cyc", cyc_o, 0);
    chk("t5_grant0", grant_o, 2'b00);
    chk("t5_noack", m_ack_o, 2'b00);
    rst_i = 1'b0;
    @(negedge clk);
    chk("t5_regrant", grant_o, 2'b01);
    wait_term(0, ack, err, rd);
    chk("t5_rdata", rd, 32'h0000_0001);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);

    // stalled slave
    slave_mode = 2;
    drv(0, 1, 1, 0, 32'h2000_0000, '0);
    @(negedge clk);
    chk("t6_grant", grant_o, 2'b01);
`ifdef WB_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chk("t6_pre_err", m_err_o, 2'b00);
        chk("t6_pre_stb", stb_o, 1);
      end else if (k == 8) begin
        chk("t6_err", m_err_o, 2'b01);
        chk("t6_stb_low", stb_o, 0);
      end else if (k == 9) begin
        chk("t6_post_err", m_err_o, 2'b00);
        chk("t6_post_stb", stb_o, 1);
        chk("t6_keep", grant_o, 2'b01);
      end
    end
`else
    repeat (12) @(negedge clk);
    chk("t6_no_err", m_err_o, 2'b00);
    chk("t6_stb", stb_o, 1);
    chk("t6_keep", grant_o, 2'b01);
`endif
    drv(0, 0, 0, 0, '0, '0);
    slave_mode = 0;
    @(negedge clk);
    chk("t6_idle", grant_o, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
